// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status inputs and
// stage enable / squash outputs.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [2:0]       id_rs;
  logic [2:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [2:0]       ex_rt;
  logic             ex_mem_read;
  logic             mem_branch;
  logic             mem_zero;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_src;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_bubble;
  logic             exmem_write;
  logic             exmem_flush;
  logic [1:0]       state;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt,
    output ex_rt, ex_mem_read,
    output mem_branch, mem_zero, mem_req, mem_ready,
    input  pc_write, pc_src, ifid_write, ifid_flush,
    input  idex_write, idex_bubble,
    input  exmem_write, exmem_flush,
    input  state, mem_timeout, stall_count, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  ex_rt, ex_mem_read,
    input  mem_branch, mem_zero, mem_req, mem_ready,
    output pc_write, pc_src, ifid_write, ifid_flush,
    output idex_write, idex_bubble,
    output exmem_write, exmem_flush,
    output state, mem_timeout, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard / sequencing controller for the 5-stage pipeline:
// load-use stalls, MEM-resolved branches, data-memory waits.
module pipeline_hazard_ctrl #(
  parameter int CNT_W        = 16,
  parameter int MEM_TIMEOUT  = 64,
  parameter int R0_HARDWIRED = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX =
    WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    BR_FLUSH   = 2'd2,
    MEM_WAIT   = 2'd3
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_taken;
  logic w_hit;
  logic w_r0;
  logic w_masked;
  logic w_load_use;
  logic w_mem_stall;
  logic w_ev_to;
  logic w_ev_stall;
  logic w_ev_br;
  logic w_ev_lu;

  logic w_pc_write;
  logic w_pc_src;
  logic w_ifid_write;
  logic w_ifid_flush;
  logic w_idex_write;
  logic w_idex_bubble;
  logic w_exmem_write;
  logic w_exmem_flush;

  // Events are made mutually exclusive here so the decoder
  // below can stay a flat one-hot case.
  always_comb begin
    w_taken = bus.mem_branch & bus.mem_zero;
    w_hit =
      (bus.id_uses_rs & (bus.id_rs == bus.ex_rt)) |
      (bus.id_uses_rt & (bus.id_rt == bus.ex_rt));
    w_r0 = (R0_HARDWIRED != 0) & (bus.ex_rt == 3'd0);
    w_masked = (r_state == LOAD_STALL) |
               (r_state == BR_FLUSH);
    w_load_use = bus.ex_mem_read & w_hit &
                 ~w_r0 & ~w_masked;
    w_mem_stall = bus.mem_req & ~bus.mem_ready;
    w_ev_to    = w_mem_stall & (r_wait == WAIT_MAX);
    w_ev_stall = w_mem_stall & ~w_ev_to;
    w_ev_br    = w_taken & ~w_mem_stall;
    w_ev_lu    = w_load_use & ~w_taken & ~w_mem_stall;
  end

  always_comb begin
    w_pc_write    = 1'b1;
    w_pc_src      = 1'b0;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_write  = 1'b1;
    w_idex_bubble = 1'b0;
    w_exmem_write = 1'b1;
    w_exmem_flush = 1'b0;
    w_state_nxt   = RUN;
    w_wait_nxt    = '0;
    unique case (1'b1)
      w_ev_to: begin
        w_exmem_flush = 1'b1;
      end
      w_ev_stall: begin
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_idex_write  = 1'b0;
        w_exmem_write = 1'b0;
        w_state_nxt   = MEM_WAIT;
        w_wait_nxt    = r_wait + WAIT_W'(1);
      end
      w_ev_br: begin
        w_pc_src      = 1'b1;
        w_ifid_flush  = 1'b1;
        w_idex_bubble = 1'b1;
        w_exmem_flush = 1'b1;
        w_state_nxt   = BR_FLUSH;
      end
      w_ev_lu: begin
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_idex_bubble = 1'b1;
        w_state_nxt   = LOAD_STALL;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wait    <= w_wait_nxt;
      r_timeout <= r_timeout | w_ev_to;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_write && r_stall_cnt != CNT_MAX)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_ev_br && r_flush_cnt != CNT_MAX)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_write    = w_pc_write;
  assign bus.pc_src      = w_pc_src;
  assign bus.ifid_write  = w_ifid_write;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_write  = w_idex_write;
  assign bus.idex_bubble = w_idex_bubble;
  assign bus.exmem_write = w_exmem_write;
  assign bus.exmem_flush = w_exmem_flush;
  assign bus.state       = r_state;
  assign bus.mem_timeout = r_timeout;
  assign bus.stall_count = r_stall_cnt;
  assign bus.flush_count = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two configurations driven
// in lockstep and checked against a rule-level model.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0] t_rs, t_rt, t_ert;
  logic t_urs, t_urt, t_rd, t_br, t_zero, t_req, t_rdy;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) if0 ();
  pipeline_hazard_ctrl_if #(.CNT_W(3))  if1 ();

  assign if0.id_rs = t_rs;
  assign if0.id_rt = t_rt;
  assign if0.id_uses_rs = t_urs;
  assign if0.id_uses_rt = t_urt;
  assign if0.ex_rt = t_ert;
  assign if0.ex_mem_read = t_rd;
  assign if0.mem_branch = t_br;
  assign if0.mem_zero = t_zero;
  assign if0.mem_req = t_req;
  assign if0.mem_ready = t_rdy;
  assign if1.id_rs = t_rs;
  assign if1.id_rt = t_rt;
  assign if1.id_uses_rs = t_urs;
  assign if1.id_uses_rt = t_urt;
  assign if1.ex_rt = t_ert;
  assign if1.ex_mem_read = t_rd;
  assign if1.mem_branch = t_br;
  assign if1.mem_zero = t_zero;
  assign if1.mem_req = t_req;
  assign if1.mem_ready = t_rdy;

  pipeline_hazard_ctrl #(
    .CNT_W(16), .MEM_TIMEOUT(64), .R0_HARDWIRED(1)
  ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

  pipeline_hazard_ctrl #(
    .CNT_W(3), .MEM_TIMEOUT(4), .R0_HARDWIRED(0)
  ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  typedef struct packed {
    logic pc_write;
    logic pc_src;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_write;
    logic exmem_flush;
    logic [1:0] state;
    logic mem_timeout;
    logic [15:0] stall;
    logic [15:0] flush;
  } out_t;

  out_t obs0, obs1, exp0, exp1;
  int n_run = 0;
  int n_fail = 0;

  int p_tmo[2] = '{64, 4};
  int p_r0[2]  = '{1, 0};
  int p_max[2] = '{65535, 7};
  int m_mode[2], m_wait[2], m_to[2], m_sc[2], m_fc[2];
  int n_mode[2], n_wait[2], n_to[2], n_sc[2], n_fc[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_wait[k] = 0; m_to[k] = 0;
      m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  task automatic model_eval(input int k, output out_t e);
    bit taken, ms, hit, lu;
    taken = t_br && t_zero;
    ms = t_req && !t_rdy;
    hit = (t_urs && t_rs == t_ert) || (t_urt && t_rt == t_ert);
    lu = t_rd && hit && !(p_r0[k] != 0 && t_ert == 3'd0)
         && m_mode[k] != 1 && m_mode[k] != 2;
    e = '0;
    e.pc_write = 1; e.ifid_write = 1;
    e.idex_write = 1; e.exmem_write = 1;
    e.state = 2'(m_mode[k]);
    e.mem_timeout = (m_to[k] != 0);
    e.stall = 16'(m_sc[k]);
    e.flush = 16'(m_fc[k]);
    n_mode[k] = 0; n_wait[k] = 0; n_to[k] = m_to[k];
    n_sc[k] = m_sc[k]; n_fc[k] = m_fc[k];
    if (ms && m_wait[k] == p_tmo[k] - 1) begin
      e.exmem_flush = 1;
      n_to[k] = 1;
    end else if (ms) begin
      e.pc_write = 0; e.ifid_write = 0;
      e.idex_write = 0; e.exmem_write = 0;
      n_mode[k] = 3;
      n_wait[k] = m_wait[k] + 1;
    end else if (taken) begin
      e.pc_src = 1; e.ifid_flush = 1;
      e.idex_bubble = 1; e.exmem_flush = 1;
      n_mode[k] = 2;
      if (m_fc[k] < p_max[k]) n_fc[k] = m_fc[k] + 1;
    end else if (lu) begin
      e.pc_write = 0; e.ifid_write = 0; e.idex_bubble = 1;
      n_mode[k] = 1;
    end
    if (!e.pc_write && m_sc[k] < p_max[k]) n_sc[k] = m_sc[k] + 1;
  endtask

  task automatic sample();
    obs0.pc_write = if0.pc_write;
    obs0.pc_src = if0.pc_src;
    obs0.ifid_write = if0.ifid_write;
    obs0.ifid_flush = if0.ifid_flush;
    obs0.idex_write = if0.idex_write;
    obs0.idex_bubble = if0.idex_bubble;
    obs0.exmem_write = if0.exmem_write;
    obs0.exmem_flush = if0.exmem_flush;
    obs0.state = if0.state;
    obs0.mem_timeout = if0.mem_timeout;
    obs0.stall = if0.stall_count;
    obs0.flush = if0.flush_count;
    obs1.pc_write = if1.pc_write;
    obs1.pc_src = if1.pc_src;
    obs1.ifid_write = if1.ifid_write;
    obs1.ifid_flush = if1.ifid_flush;
    obs1.idex_write = if1.idex_write;
    obs1.idex_bubble = if1.idex_bubble;
    obs1.exmem_write = if1.exmem_write;
    obs1.exmem_flush = if1.exmem_flush;
    obs1.state = if1.state;
    obs1.mem_timeout = if1.mem_timeout;
    obs1.stall = 16'(if1.stall_count);
    obs1.flush = 16'(if1.flush_count);
  endtask

  // One cycle: sample and predict at negedge, commit at posedge.
  task automatic tick();
    @(negedge clk);
    sample();
    model_eval(0, exp0);
    model_eval(1, exp1);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = n_mode[k]; m_wait[k] = n_wait[k];
      m_to[k] = n_to[k]; m_sc[k] = n_sc[k]; m_fc[k] = n_fc[k];
    end
    #1;
  endtask

  task automatic idle();
    t_rs = 0; t_rt = 0; t_ert = 0; t_urs = 0; t_urt = 0;
    t_rd = 0; t_br = 0; t_zero = 0; t_req = 0; t_rdy = 0;
  endtask

  task automatic test_reset();
    out_t r;
    r = '0;
    r.pc_write = 1; r.ifid_write = 1;
    r.idex_write = 1; r.exmem_write = 1;
    idle();
    rst_n = 0;
    model_reset();
    #3;
    sample();
    n_run++;
    if (obs0 !== r) begin
      n_fail++;
      $display("FAIL reset0 got %h want %h", obs0, r);
    end
    n_run++;
    if (obs1 !== r) begin
      n_fail++;
      $display("FAIL reset1 got %h want %h", obs1, r);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_load_use();
    idle();
    t_rd = 1; t_ert = 3; t_rs = 3; t_urs = 1;
    tick();
    n_run++;
    if ({obs0.pc_write, obs0.ifid_write, obs0.idex_bubble} !== 3'b001) begin
      n_fail++;
      $display("FAIL lu_stall got %b want 001",
        {obs0.pc_write, obs0.ifid_write, obs0.idex_bubble});
    end
    n_run++;
    if (obs1 !== exp1) begin
      n_fail++;
      $display("FAIL lu_model1 got %h want %h", obs1, exp1);
    end
    tick();
    n_run++;
    if ({obs0.state, obs0.pc_write, obs0.idex_bubble} !== 4'b0110) begin
      n_fail++;
      $display("FAIL lu_masked got %b want 0110",
        {obs0.state, obs0.pc_write, obs0.idex_bubble});
    end
    idle();
    tick();
    n_run++;
    if (obs0.state !== 2'd0 || obs0.stall !== 16'd1) begin
      n_fail++;
      $display("FAIL lu_after state %0d stall %0d want 0 1",
        obs0.state, obs0.stall);
    end
    n_run++;
    if (obs1 !== exp1) begin
      n_fail++;
      $display("FAIL lu_after1 got %h want %h", obs1, exp1);
    end
  endtask

  task automatic test_r0_mask();
    idle();
    t_rd = 1; t_ert = 0; t_rs = 0; t_urs = 1;
    tick();
    n_run++;
    if (obs0.pc_write !== 1'b1 || obs0.idex_bubble !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_hard pc_write %b bubble %b want 1 0",
        obs0.pc_write, obs0.idex_bubble);
    end
    n_run++;
    if (obs1.pc_write !== 1'b0 || obs1.idex_bubble !== 1'b1) begin
      n_fail++;
      $display("FAIL r0_soft pc_write %b bubble %b want 0 1",
        obs1.pc_write, obs1.idex_bubble);
    end
    idle();
    tick();
    tick();
    n_run++;
    if (obs1 !== exp1 || obs0 !== exp0) begin
      n_fail++;
      $display("FAIL r0_settle got %h/%h want %h/%h",
        obs0, obs1, exp0, exp1);
    end
  endtask

  task automatic test_branch();
    idle();
    t_br = 1; t_zero = 1;
    tick();
    n_run++;
    if ({obs0.pc_src, obs0.pc_write, obs0.ifid_flush,
         obs0.idex_bubble, obs0.exmem_flush} !== 5'b11111) begin
      n_fail++;
      $display("FAIL br_redirect got %b want 11111",
        {obs0.pc_src, obs0.pc_write, obs0.ifid_flush,
         obs0.idex_bubble, obs0.exmem_flush});
    end
    idle();
    tick();
    n_run++;
    if (obs0.state !== 2'd2 || obs0.flush !== 16'd1) begin
      n_fail++;
      $display("FAIL br_flush state %0d flush %0d want 2 1",
        obs0.state, obs0.flush);
    end
    tick();
    n_run++;
    if (obs0.state !== 2'd0) begin
      n_fail++;
      $display("FAIL br_run state %0d want 0", obs0.state);
    end
    t_br = 1; t_zero = 0;
    tick();
    n_run++;
    if (obs0.pc_src !== 1'b0 || obs0.ifid_flush !== 1'b0 ||
        obs1 !== exp1) begin
      n_fail++;
      $display("FAIL br_not_taken pc_src %b flush %b want 0 0",
        obs0.pc_src, obs0.ifid_flush);
    end
    idle();
    tick();
  endtask

  task automatic test_timeout();
    idle();
    t_req = 1; t_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_run++;
      if ({obs1.pc_write, obs1.ifid_write, obs1.idex_write,
           obs1.exmem_write, obs1.exmem_flush} !== 5'b00000) begin
        n_fail++;
        $display("FAIL tmo_freeze%0d got %b want 00000", i,
          {obs1.pc_write, obs1.ifid_write, obs1.idex_write,
           obs1.exmem_write, obs1.exmem_flush});
      end
    end
    tick();
    n_run++;
    if ({obs1.exmem_flush, obs1.pc_write, obs1.ifid_write,
         obs1.idex_write, obs1.exmem_write,
         obs1.mem_timeout} !== 6'b111110) begin
      n_fail++;
      $display("FAIL tmo_pulse got %b want 111110",
        {obs1.exmem_flush, obs1.pc_write, obs1.ifid_write,
         obs1.idex_write, obs1.exmem_write, obs1.mem_timeout});
    end
    n_run++;
    if (obs0.exmem_write !== 1'b0 || obs0.exmem_flush !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_long write %b flush %b want 0 0",
        obs0.exmem_write, obs0.exmem_flush);
    end
    idle();
    tick();
    n_run++;
    if (obs1.mem_timeout !== 1'b1 || obs1.state !== 2'd0 ||
        obs0.mem_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_sticky t1 %b s1 %0d t0 %b want 1 0 0",
        obs1.mem_timeout, obs1.state, obs0.mem_timeout);
    end
  endtask

  task automatic test_mem_wait();
    int base;
    base = m_sc[0];
    idle();
    t_req = 1; t_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_run++;
      if ({obs0.pc_write, obs0.ifid_write, obs0.idex_write,
           obs0.exmem_write} !== 4'b0000 || obs1 !== exp1) begin
        n_fail++;
        $display("FAIL mw_freeze%0d got %b want 0000", i,
          {obs0.pc_write, obs0.ifid_write, obs0.idex_write,
           obs0.exmem_write});
      end
    end
    t_rdy = 1;
    tick();
    n_run++;
    if ({obs0.state, obs0.pc_write, obs0.ifid_write,
         obs0.idex_write, obs0.exmem_write} !== 6'b111111) begin
      n_fail++;
      $display("FAIL mw_release got %b want 111111",
        {obs0.state, obs0.pc_write, obs0.ifid_write,
         obs0.idex_write, obs0.exmem_write});
    end
    idle();
    tick();
    n_run++;
    if (obs0.state !== 2'd0 || obs0.stall !== 16'(base + 5)) begin
      n_fail++;
      $display("FAIL mw_count state %0d stall %0d want 0 %0d",
        obs0.state, obs0.stall, base + 5);
    end
  endtask

  task automatic test_priority();
    idle();
    t_br = 1; t_zero = 1; t_req = 1; t_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_run++;
      if ({obs0.pc_src, obs0.pc_write} !== 2'b00 || obs1 !== exp1) begin
        n_fail++;
        $display("FAIL pri_freeze%0d got %b want 00", i,
          {obs0.pc_src, obs0.pc_write});
      end
    end
    t_rdy = 1;
    tick();
    n_run++;
    if ({obs0.pc_src, obs0.ifid_flush, obs0.pc_write} !== 3'b111) begin
      n_fail++;
      $display("FAIL pri_redirect got %b want 111",
        {obs0.pc_src, obs0.ifid_flush, obs0.pc_write});
    end
    idle();
    tick();
    n_run++;
    if (obs0.state !== 2'd2 || obs0 !== exp0 || obs1 !== exp1) begin
      n_fail++;
      $display("FAIL pri_after got %h want %h", obs0, exp0);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    idle();
    t_req = 1; t_rdy = 0;
    tick();
    tick();
    #2;
    rst_n = 0;
    #1;
    n_run++;
    if (if0.state !== 2'd0 || if0.stall_count !== 16'd0 ||
        if0.flush_count !== 16'd0 || if0.mem_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async0 st %0d sc %0d fc %0d to %b want 0",
        if0.state, if0.stall_count, if0.flush_count, if0.mem_timeout);
    end
    n_run++;
    if (if1.state !== 2'd0 || if1.stall_count !== 3'd0 ||
        if1.flush_count !== 3'd0 || if1.mem_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async1 st %0d sc %0d fc %0d to %b want 0",
        if1.state, if1.stall_count, if1.flush_count, if1.mem_timeout);
    end
    idle();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    tick();
    n_run++;
    if (obs0 !== exp0 || obs1 !== exp1) begin
      n_fail++;
      $display("FAIL rst_resume got %h/%h want %h/%h",
        obs0, obs1, exp0, exp1);
    end
  endtask

  task automatic test_saturation();
    idle();
    t_req = 1; t_rdy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_run++;
      if (obs1 !== exp1 || obs0 !== exp0) begin
        n_fail++;
        $display("FAIL sat_stall%0d got %h/%h want %h/%h", i,
          obs0, obs1, exp0, exp1);
      end
    end
    idle();
    tick();
    n_run++;
    if (obs1.stall !== 16'd7) begin
      n_fail++;
      $display("FAIL sat_stall_cnt got %0d want 7", obs1.stall);
    end
    t_br = 1; t_zero = 1;
    repeat (10) tick();
    idle();
    tick();
    n_run++;
    if (obs1.flush !== 16'd7 || obs0.flush !== 16'd10) begin
      n_fail++;
      $display("FAIL sat_flush_cnt got %0d/%0d want 10/7",
        obs0.flush, obs1.flush);
    end
  endtask

  task automatic test_random();
    int rdy_pct;
    rdy_pct = 50;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) rdy_pct = int'($urandom_range(10, 90));
      t_rs = 3'($urandom_range(0, 3));
      t_rt = 3'($urandom_range(0, 3));
      t_ert = 3'($urandom_range(0, 3));
      t_urs = 1'($urandom_range(0, 1));
      t_urt = 1'($urandom_range(0, 1));
      t_rd = 1'($urandom_range(0, 1));
      t_br = ($urandom_range(0, 3) == 0);
      t_zero = 1'($urandom_range(0, 1));
      t_req = 1'($urandom_range(0, 1));
      t_rdy = ($urandom_range(0, 99) < rdy_pct);
      tick();
      n_run++;
      if (obs0 !== exp0) begin
        n_fail++;
        $display("FAIL rand0 cyc %0d got %h want %h", i, obs0, exp0);
      end
      n_run++;
      if (obs1 !== exp1) begin
        n_fail++;
        $display("FAIL rand1 cyc %0d got %h want %h", i, obs1, exp1);
      end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_r0_mask();
    test_branch();
    test_timeout();
    test_mem_wait();
    test_priority();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
